// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings
// and the width of the stall / start-up down-counters.
package pipe_hazard_ctrl_pkg;

   localparam int PHC_CNT_W = 4;

   typedef enum logic [1:0] {
      PHC_IDLE    = 2'd0,
      PHC_LDUSE   = 2'd1,
      PHC_RELEASE = 2'd2
   } phc_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_ld_hazard_det.sv
// ld_hazard_det: combinational load-use comparator. Flags when the instruction
// in ID reads a register that the load currently in EX is about to write.
// Kept standalone so the forwarding unit can reuse the same compare.
//
// Ports:
//   inst_rs1_id, inst_rs2_id       in  ID source register numbers
//   inst_rs1_valid, inst_rs2_valid in  source register is really read
//   cmd_ld_ex                      in  EX instruction is a load
//   rd_adr_ex                      in  EX destination register
//   wbk_rd_reg_ex                  in  EX instruction writes rd
//   ld_hit                         out load-use hazard present
module ld_hazard_det
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [4:0] inst_rs1_id,
   input  logic [4:0] inst_rs2_id,
   input  logic       inst_rs1_valid,
   input  logic       inst_rs2_valid,
   input  logic       cmd_ld_ex,
   input  logic [4:0] rd_adr_ex,
   input  logic       wbk_rd_reg_ex,
   output logic       ld_hit
);

   logic rs1_match;
   logic rs2_match;

   assign rs1_match = inst_rs1_valid & (inst_rs1_id == rd_adr_ex);
   assign rs2_match = inst_rs2_valid & (inst_rs2_id == rd_adr_ex);

   // x0 is hardwired to zero, so a load targeting it never creates a hazard.
   assign ld_hit = cmd_ld_ex & wbk_rd_reg_ex & (rd_adr_ex != 5'd0)
                 & (rs1_match | rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencing controller for the RV32I core.
// Generates stall controls for the IF/ID/EX stage registers, inserts
// load-use bubbles, holds the pipe while data memory is busy, sequences
// pipeline reset at start-up and on flush, and counts stall cycles.
//
// Ports:
//   clk, rst_n          in  clock, async active-low reset
//   cpu_run             in  pipeline held in reset while low
//   flush_req           in  one-cycle flush request
//   inst_rs*_id/_valid  in  ID source registers
//   cmd_ld_ex, rd_adr_ex, wbk_rd_reg_ex  in  EX instruction info
//   dmem_busy           in  data memory busy
//   stall               out freeze stage registers (combinational)
//   stall_1shot         out first cycle of a stall run
//   stall_dly           out stall delayed one cycle
//   rst_pipe            out synchronous pipeline clear (registered)
//   stall_cycles        out saturating stall-cycle counter
//
// State table:
//   state        | meaning
//   PHC_IDLE     | no hazard in progress; ld_hit stalls directly
//   PHC_LDUSE    | inserting extra load-use bubbles, cnt counts down
//   PHC_RELEASE  | load leaves EX this cycle; ld_hit is masked
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int LDUSE_CYCLES    = 1,
   parameter int RST_PIPE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_run,
   input  logic        flush_req,
   input  logic [4:0]  inst_rs1_id,
   input  logic [4:0]  inst_rs2_id,
   input  logic        inst_rs1_valid,
   input  logic        inst_rs2_valid,
   input  logic        cmd_ld_ex,
   input  logic [4:0]  rd_adr_ex,
   input  logic        wbk_rd_reg_ex,
   input  logic        dmem_busy,
   output logic        stall,
   output logic        stall_1shot,
   output logic        stall_dly,
   output logic        rst_pipe,
   output logic [31:0] stall_cycles
);

   localparam logic [PHC_CNT_W-1:0] LDUSE_LOAD = PHC_CNT_W'(LDUSE_CYCLES - 2);
   localparam logic [PHC_CNT_W-1:0] RST_LOAD   = PHC_CNT_W'(RST_PIPE_CYCLES);

   phc_state_e           state;
   phc_state_e           state_nxt;
   logic [PHC_CNT_W-1:0] cnt;
   logic [PHC_CNT_W-1:0] cnt_nxt;
   logic [PHC_CNT_W-1:0] rst_cnt;
   logic                 rst_pipe_nxt;
   logic                 stall_q;
   logic                 ld_hit;

   ld_hazard_det u_ld_hazard_det (
      .inst_rs1_id    (inst_rs1_id),
      .inst_rs2_id    (inst_rs2_id),
      .inst_rs1_valid (inst_rs1_valid),
      .inst_rs2_valid (inst_rs2_valid),
      .cmd_ld_ex      (cmd_ld_ex),
      .rd_adr_ex      (rd_adr_ex),
      .wbk_rd_reg_ex  (wbk_rd_reg_ex),
      .ld_hit         (ld_hit)
   );

   // rst_cnt is reloaded for as long as cpu_run is low, so the start-up
   // countdown begins on the first cycle cpu_run is sampled high.
   assign rst_pipe_nxt = ~cpu_run | (rst_cnt != '0) | flush_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_cnt  <= RST_LOAD;
         rst_pipe <= 1'b1;
      end else begin
         rst_pipe <= rst_pipe_nxt;
         if (!cpu_run) begin
            rst_cnt <= RST_LOAD;
         end else if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         PHC_IDLE: begin
            if (ld_hit && !dmem_busy) begin
               if (LDUSE_CYCLES == 1) begin
                  state_nxt = PHC_RELEASE;
               end else begin
                  state_nxt = PHC_LDUSE;
                  cnt_nxt   = LDUSE_LOAD;
               end
            end
         end
         PHC_LDUSE: begin
            if (!dmem_busy) begin
               if (cnt == '0) begin
                  state_nxt = PHC_RELEASE;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
         end
         PHC_RELEASE: begin
            if (!dmem_busy) begin
               state_nxt = PHC_IDLE;
            end
         end
         default: begin
            state_nxt = PHC_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Clearing on rst_pipe_nxt as well as rst_pipe makes a flush take effect
   // in the very cycle rst_pipe rises, so no hazard survives a flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= PHC_IDLE;
         cnt   <= '0;
      end else if (rst_pipe || rst_pipe_nxt) begin
         state <= PHC_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign stall = ~rst_pipe & (dmem_busy
                             | ((state == PHC_IDLE) & ld_hit)
                             | (state == PHC_LDUSE));

   assign stall_1shot = stall & ~stall_q;
   assign stall_dly   = stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= 1'b0;
      end else if (rst_pipe) begin
         stall_q <= 1'b0;
      end else begin
         stall_q <= stall;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the RV32I core. It generates the `stall`, `stall_1shot`, `stall_dly` and `rst_pipe` controls consumed by the IF/ID/EX stage registers and by the ID-stage register-file roll-back path. It detects load-use hazards between the instruction in ID and a load in EX, and holds the pipe while data memory is busy. It also sequences pipeline reset at CPU start and on flush requests, and keeps a stall-cycle performance counter.

## Interface
Parameters:
- `LDUSE_CYCLES`, default 1: stall cycles inserted per load-use hazard, legal range 1..15.
- `RST_PIPE_CYCLES`, default 2: cycles `rst_pipe` stays high after `cpu_run` rises, legal range 1..15.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cpu_run`  in  1  level; the pipeline is held in reset while this is low.
- `flush_req`  in  1  one-cycle pulse from trap/mret logic requesting a pipeline flush.
- `inst_rs1_id`, `inst_rs2_id`  in  5 each  source register numbers in ID.
- `inst_rs1_valid`, `inst_rs2_valid`  in  1 each  the source register is actually read.
- `cmd_ld_ex`  in  1  the instruction in EX is a load.
- `rd_adr_ex`  in  5  destination register of the EX instruction.
- `wbk_rd_reg_ex`  in  1  the EX instruction writes `rd`.
- `dmem_busy`  in  1  data memory cannot accept or return data this cycle.
- `stall`  out  1  freeze the IF/ID and ID/EX registers (combinational).
- `stall_1shot`  out  1  first cycle of a stall run (combinational).
- `stall_dly`  out  1  `stall` delayed by one cycle (registered).
- `rst_pipe`  out  1  synchronous pipeline clear (registered).
- `stall_cycles`  out  32  saturating count of cycles with `stall` high.

## Operation
- Load-use hit: `ld_hit = cmd_ld_ex & wbk_rd_reg_ex & (rd_adr_ex != 0) & ((inst_rs1_valid & inst_rs1_id == rd_adr_ex) | (inst_rs2_valid & inst_rs2_id == rd_adr_ex))`.
- State machine states: IDLE, LDUSE, RELEASE.
- IDLE:
  - On `ld_hit & ~dmem_busy`, go to RELEASE if `LDUSE_CYCLES == 1`.
  - Otherwise go to LDUSE and load `cnt = LDUSE_CYCLES - 2`.
  - While `dmem_busy` is high, stay in IDLE.
- LDUSE:
  - If `dmem_busy`, hold `cnt` and the state.
  - Else if `cnt == 0`, go to RELEASE.
  - Else decrement `cnt`.
- RELEASE:
  - `ld_hit` is masked, because the EX stage still holds the load for this one cycle.
  - Go to IDLE when `~dmem_busy`.
- Stall equation: `stall = ~rst_pipe & (dmem_busy | (state==IDLE & ld_hit) | state==LDUSE)`.
- Stall edge outputs:
  - `stall_q` is `stall` registered.
  - `stall_1shot = stall & ~stall_q`.
  - `stall_dly = stall_q`.
- `rst_pipe` sequencing:
  - While `cpu_run` is 0, `rst_pipe` is 1.
  - On the `cpu_run` rising edge (sampled), `rst_pipe` stays 1 for exactly `RST_PIPE_CYCLES` further cycles, then goes to 0.
  - `flush_req` sets `rst_pipe` to 1 for exactly the next cycle.
- While `rst_pipe` is 1:
  - The state goes to IDLE and `cnt` to 0.
  - `stall_q` is cleared.
  - `stall` is forced to 0.
- `stall_cycles`:
  - Increments when `stall` is 1 and saturates at 0xFFFF_FFFF.
  - It is not cleared by `rst_pipe`; only `rst_n` clears it.

## Timing
- Reset values:
  - `rst_pipe` = 1.
  - `stall_q` and `stall_dly` = 0.
  - `stall` and `stall_1shot` = 0, because they are gated by `rst_pipe`.
  - State = IDLE, `cnt` = 0, `stall_cycles` = 0.
- `stall` responds to `ld_hit` and `dmem_busy` in the same cycle, with zero latency.
- A load-use hazard gives exactly `LDUSE_CYCLES` stall cycles when `dmem_busy` stays 0. The consumer advances on the clock edge ending the last stall cycle.
- Simultaneous events:
  - `flush_req` and a stall in the same cycle: `stall` is still driven that cycle. The next cycle has `rst_pipe` = 1, `stall` = 0, and the FSM in IDLE.
  - `flush_req` while the start-up countdown is running: the countdown continues, and `rst_pipe` stays 1 until it ends.
  - `cpu_run` falling mid-stall: `rst_pipe` = 1 on the next cycle, which aborts the stall.
- Back-to-back loads: a new `ld_hit` can first be accepted in the cycle after RELEASE.

## Structure
- A shared include file holds the state encodings `PHC_IDLE`, `PHC_LDUSE`, `PHC_RELEASE` and the counter width (4 bits).
- One sub-module, `ld_hazard_det`, holds the combinational `ld_hit` comparator so the forwarding unit can reuse it.
- Everything else sits in the top module: the FSM, `cnt`, the `rst_pipe` sequencer, `stall_q`, and the performance counter.

## Test plan
- Start-up: `rst_n` released with `cpu_run` = 0, then `cpu_run` rises at cycle 5 → `rst_pipe` is 1 through cycle 7 and 0 from cycle 8; `stall` is 0 throughout.
- Load-use: `cmd_ld_ex` = 1, `rd_adr_ex` = 5, `inst_rs2_id` = 5, `inst_rs2_valid` = 1, with `LDUSE_CYCLES` = 1 → `stall` and `stall_1shot` are 1 for one cycle; `stall_dly` is 1 the next cycle; no re-stall in RELEASE.
- `rd_adr_ex` = 0, or `wbk_rd_reg_ex` = 0, or a matching but invalid rs → `stall` stays 0.
- With `LDUSE_CYCLES` = 3, `dmem_busy` pulses for 2 cycles during LDUSE → `stall` is high for 5 consecutive cycles; `stall_1shot` fires only on the first; `stall_cycles` increases by 5.
- `flush_req` during LDUSE → `rst_pipe` is 1 next cycle; `stall` drops to 0; the FSM is in IDLE; `stall_dly` is 0 the following cycle.
- `stall_cycles` preloaded to 0xFFFF_FFFE via force, then 3 stall cycles → holds at 0xFFFF_FFFF.
